// File: rtl/vdff.sv
// rtl/vdff.sv - parameterised pipeline registers: vdff (plain D) and vdff_en (D with load enable)
// Synchronous active-high reset clears Q to zero and takes priority over the enable.

module vdff_en #(
  parameter int n = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] D,
  output logic [n-1:0] Q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= '0;
    end else if (en) begin
      Q <= D;
    end
  end

endmodule

// A plain register is the enabled register with the enable tied high, so both share one behaviour.
module vdff #(
  parameter int n = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] D,
  output logic [n-1:0] Q
);

  vdff_en #(
    .n(n)
  ) u_reg (
    .clk(clk),
    .rst(rst),
    .en (1'b1),
    .D  (D),
    .Q  (Q)
  );

endmodule

// File: tb/tb_vdff.sv
// tb/tb_vdff.sv - self-checking bench for vdff (n=1) and vdff_en (n=8)
module tb_vdff;

  logic       clk;
  logic       rst_a;
  logic       en_a;
  logic [7:0] d_a;
  logic [7:0] q_a;

  logic       rst_b;
  logic       x_b;
  logic       tog_b;
  logic       sticky_mode;
  logic [0:0] d_b;
  logic [0:0] q_b;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[12];

  assign d_b = sticky_mode ? (x_b | q_b) : tog_b;

  vdff_en #(.n(8)) u_en (
    .clk(clk),
    .rst(rst_a),
    .en (en_a),
    .D  (d_a),
    .Q  (q_a)
  );

  vdff #(.n(1)) u_dut (
    .clk(clk),
    .rst(rst_b),
    .D  (d_b),
    .Q  (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic r, input logic e, input logic [7:0] d);
    @(negedge clk);
    rst_a = r;
    en_a  = e;
    d_a   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic r, input logic x, input logic t);
    @(negedge clk);
    rst_b = r;
    x_b   = x;
    tog_b = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_a = 1'b0; en_a = 1'b0; d_a = 8'h00;
    rst_b = 1'b0; x_b = 1'b0; tog_b = 1'b0; sticky_mode = 1'b1;

    vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 8'hA5};
    vecs[2]  = '{1'b1, 1'b1, 8'h3C, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h3C, 8'h3C};
    vecs[4]  = '{1'b0, 1'b0, 8'hFF, 8'h3C};
    vecs[5]  = '{1'b0, 1'b0, 8'hFF, 8'h3C};
    vecs[6]  = '{1'b0, 1'b0, 8'hFF, 8'h3C};
    vecs[7]  = '{1'b0, 1'b1, 8'hFF, 8'hFF};
    vecs[8]  = '{1'b0, 1'b1, 8'h80, 8'h80};
    vecs[9]  = '{1'b0, 1'b0, 8'h01, 8'h80};
    vecs[10] = '{1'b1, 1'b0, 8'h55, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 8'h7F, 8'h7F};

    for (int i = 0; i < 12; i++) begin
      step_a(vecs[i].rst, vecs[i].en, vecs[i].d);
      check($sformatf("vec%0d", i), q_a, vecs[i].exp_q);
    end

    // Reset with en=1 and new D: Q holds before the edge, clears at it
    step_a(1'b0, 1'b1, 8'hA5);
    check("load_a5", q_a, 8'hA5);
    @(negedge clk);
    rst_a = 1'b1; en_a = 1'b1; d_a = 8'h3C;
    #1;
    check("pre_edge_hold", q_a, 8'hA5);
    @(posedge clk);
    #1;
    check("rst_over_en", q_a, 8'h00);

    // Sub-cycle reset pulse between edges has no effect
    step_a(1'b0, 1'b1, 8'h80);
    check("load_80", q_a, 8'h80);
    @(negedge clk);
    en_a = 1'b0;
    #1 rst_a = 1'b1;
    #2 rst_a = 1'b0;
    #1;
    check("rst_glitch_mid", q_a, 8'h80);
    @(posedge clk);
    #1;
    check("rst_glitch_edge", q_a, 8'h80);

    // Sticky-halt loop on the plain register
    step_b(1'b1, 1'b0, 1'b0);
    check("halt_reset", {7'd0, q_b}, 8'h00);
    step_b(1'b0, 1'b0, 1'b0);
    check("halt_idle", {7'd0, q_b}, 8'h00);
    step_b(1'b0, 1'b1, 1'b0);
    check("halt_set", {7'd0, q_b}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step_b(1'b0, 1'b0, 1'b0);
      check($sformatf("halt_sticky%0d", i), {7'd0, q_b}, 8'h01);
    end
    step_b(1'b1, 1'b0, 1'b0);
    check("halt_clear", {7'd0, q_b}, 8'h00);

    // Toggling D: Q is D delayed by one edge
    @(negedge clk);
    sticky_mode = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic t;
      t = i[0];
      step_b(1'b0, 1'b0, t);
      check($sformatf("toggle%0d", i), {7'd0, q_b}, {7'd0, t});
      @(negedge clk);
      #1;
      check($sformatf("toggle_hold%0d", i), {7'd0, q_b}, {7'd0, t});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
